warp_ibuf: RTL and testbench

Dual-entry-per-cycle instruction buffer that sits between the fetch stage (which holds AHB read data) and the dual-issue decode stage. It accepts 0, 1 or 2 instructions per cycle from fetch and presents up to the 2 oldest to decode, which consumes 0, 1 or 2 per cycle. It absorbs rate mismatch when decode can take only one instruction of a pair, and it supports a single-cycle flush for redirects.

---
 rtl/warp_ibuf.sv | 100 ++++++++++
 tb/tb_warp_ibuf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/warp_ibuf.sv
// Dual-in / dual-out instruction buffer between fetch and dual-issue decode.
// Circular storage with a registered occupancy count and a single-cycle flush.
module warp_ibuf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [1:0]       i_wcount,
  output logic [1:0]       o_wcapacity,
  input  logic [WIDTH-1:0] i_wdata0,
  input  logic [WIDTH-1:0] i_wdata1,
  output logic [1:0]       o_rcount,
  output logic [WIDTH-1:0] o_rdata0,
  output logic [WIDTH-1:0] o_rdata1,
  input  logic [1:0]       i_rcount
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, rd_ptr_p1;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [OW-1:0]    occ_q, occ_d;
  logic [OW-1:0]    free;
  logic [1:0]       wreq, rreq, wn, rn;
  logic             we0, we1;

  // Count handshake: each cycle the producer offers i_wcount entries against
  // o_wcapacity and the consumer takes i_rcount against o_rcount; the
  // transferred amount is the minimum of the two, committed at the clock edge.
  assign free        = OW'(DEPTH) - occ_q;
  assign o_wcapacity = (free >= OW'(2)) ? 2'd2 : free[1:0];
  assign o_rcount    = (occ_q >= OW'(2)) ? 2'd2 : occ_q[1:0];

  assign wreq = (i_wcount == 2'd3) ? 2'd2 : i_wcount;
  assign rreq = (i_rcount == 2'd3) ? 2'd2 : i_rcount;
  assign wn   = (wreq > o_wcapacity) ? o_wcapacity : wreq;
  assign rn   = (rreq > o_rcount) ? o_rcount : rreq;

  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign rd_ptr_p1 = rd_ptr_q + AW'(1);

  assign o_rdata0 = mem_q[rd_ptr_q];
  assign o_rdata1 = mem_q[rd_ptr_p1];

  assign we0 = !i_flush && (wn != 2'd0);
  assign we1 = !i_flush && (wn == 2'd2);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wn);
    rd_ptr_d = rd_ptr_q + AW'(rn);
    occ_d    = occ_q + OW'(wn) - OW'(rn);
    // Flush empties the buffer by snapping the read pointer to the write pointer.
    if (i_flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (we0) mem_q[wr_ptr_q]  <= i_wdata0;
      if (we1) mem_q[wr_ptr_p1] <= i_wdata1;
    end
  end

`ifdef WARP_FORMAL
  a_occ_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    occ_q <= OW'(DEPTH));
  a_ptr_occ: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    AW'(wr_ptr_q - rd_ptr_q) == AW'(occ_q));
  a_out_cnt: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_rcount <= 2'd2) && (o_wcapacity <= 2'd2));
  a_wr_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_wcount <= o_wcapacity);
  a_rd_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_rcount <= o_rcount);
  c_full: cover property (@(posedge i_clk) occ_q == OW'(DEPTH));
  c_empty: cover property (@(posedge i_clk) occ_q == '0);
  c_wr_wrap: cover property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_flush && (wr_ptr_d < wr_ptr_q));
  c_rd_wrap: cover property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_flush && (rd_ptr_d < rd_ptr_q));
  c_flush_full: cover property (@(posedge i_clk) disable iff (!i_rst_n)
    i_flush && (occ_q == OW'(DEPTH)));
`endif

endmodule

// File: tb/tb_warp_ibuf.sv
// Directed bench for warp_ibuf: a queue scoreboard follows every transfer and
// hand-computed checks pin the occupancy/capacity boundary cases.
module tb_warp_ibuf;

  localparam int W = 32;
  localparam int D = 4;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_flush;
  logic [1:0]   i_wcount;
  logic [1:0]   o_wcapacity;
  logic [W-1:0] i_wdata0;
  logic [W-1:0] i_wdata1;
  logic [1:0]   o_rcount;
  logic [W-1:0] o_rdata0;
  logic [W-1:0] o_rdata1;
  logic [1:0]   i_rcount;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  warp_ibuf #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_wcount    (i_wcount),
    .o_wcapacity (o_wcapacity),
    .i_wdata0    (i_wdata0),
    .i_wdata1    (i_wdata1),
    .o_rcount    (o_rcount),
    .o_rdata0    (o_rdata0),
    .o_rdata1    (o_rdata1),
    .i_rcount    (i_rcount)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one cycle of stimulus, return just after its edge with inputs idle
  task automatic step(input logic fl, input logic [1:0] wc, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input logic [1:0] rc);
    i_flush  = fl;
    i_wcount = wc;
    i_wdata0 = d0;
    i_wdata1 = d1;
    i_rcount = rc;
    @(posedge i_clk);
    #1;
    i_flush  = 1'b0;
    i_wcount = 2'd0;
    i_rcount = 2'd0;
  endtask

  // scoreboard monitor: compare presented outputs, then apply this cycle's transfer
  always @(negedge i_clk) begin
    int sz, cap, rc_exp, wreq, rreq, wn, rn;
    if (!i_rst_n) begin
      exp_q.delete();
    end else begin
      sz     = exp_q.size();
      cap    = (D - sz > 2) ? 2 : D - sz;
      rc_exp = (sz > 2) ? 2 : sz;
      chk("sb_rcount", W'(o_rcount), W'(rc_exp));
      chk("sb_wcapacity", W'(o_wcapacity), W'(cap));
      if (sz >= 1) chk("sb_rdata0", o_rdata0, exp_q[0]);
      if (sz >= 2) chk("sb_rdata1", o_rdata1, exp_q[1]);
      wreq = (i_wcount == 2'd3) ? 2 : int'(i_wcount);
      rreq = (i_rcount == 2'd3) ? 2 : int'(i_rcount);
      wn   = (wreq > cap) ? cap : wreq;
      rn   = (rreq > rc_exp) ? rc_exp : rreq;
      if (i_flush) begin
        exp_q.delete();
      end else begin
        repeat (rn) void'(exp_q.pop_front());
        if (wn >= 1) exp_q.push_back(i_wdata0);
        if (wn == 2) exp_q.push_back(i_wdata1);
      end
    end
  end

  initial begin
    i_rst_n  = 1'b0;
    i_flush  = 1'b0;
    i_wcount = 2'd0;
    i_rcount = 2'd0;
    i_wdata0 = '0;
    i_wdata1 = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // reset state
    chk("rst_rcount", W'(o_rcount), 32'd0);
    chk("rst_wcap", W'(o_wcapacity), 32'd2);
    chk("rst_rdata0", o_rdata0, 32'h0);
    chk("rst_rdata1", o_rdata1, 32'h0);

    // single pair write, visible the following cycle
    step(1'b0, 2'd2, 32'h11, 32'h22, 2'd0);
    chk("pair_rcount", W'(o_rcount), 32'd2);
    chk("pair_rdata0", o_rdata0, 32'h11);
    chk("pair_rdata1", o_rdata1, 32'h22);
    chk("pair_wcap", W'(o_wcapacity), 32'd2);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("pair_drain", W'(o_rcount), 32'd0);

    // fill to full; an extra offer is ignored
    step(1'b0, 2'd2, 32'h1, 32'h2, 2'd0);
    step(1'b0, 2'd2, 32'h3, 32'h4, 2'd0);
    chk("full_wcap", W'(o_wcapacity), 32'd0);
    step(1'b0, 2'd2, 32'h5, 32'h6, 2'd0);
    chk("full_ign_wcap", W'(o_wcapacity), 32'd0);
    chk("full_ign_rdata0", o_rdata0, 32'h1);
    chk("full_ign_rdata1", o_rdata1, 32'h2);

    // read one from full, then a pair offer stores only data0
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd1);
    chk("rd1_rdata0", o_rdata0, 32'h2);
    chk("rd1_wcap", W'(o_wcapacity), 32'd1);
    step(1'b0, 2'd2, 32'h5, 32'h6, 2'd0);
    chk("part_wcap", W'(o_wcapacity), 32'd0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("part_rdata0", o_rdata0, 32'h4);
    chk("part_rdata1", o_rdata1, 32'h5);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd3);
    chk("part_empty", W'(o_rcount), 32'd0);

    // empty over-read, then one-entry over-read
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("empty_rcount", W'(o_rcount), 32'd0);
    chk("empty_wcap", W'(o_wcapacity), 32'd2);
    step(1'b0, 2'd1, 32'h77, 32'h88, 2'd0);
    chk("one_rcount", W'(o_rcount), 32'd1);
    chk("one_rdata0", o_rdata0, 32'h77);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("one_drain", W'(o_rcount), 32'd0);

    // steady stream: two offered, one consumed per cycle; settles at occ=3
    for (int i = 0; i < 8; i++)
      step(1'b0, 2'd2, 32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i), (i == 0) ? 2'd0 : 2'd1);
    chk("stream_rcount", W'(o_rcount), 32'd2);
    chk("stream_wcap", W'(o_wcapacity), 32'd1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("stream_drain", W'(o_rcount), 32'd0);

    // flush at occ=3 beats same-cycle write and read
    step(1'b0, 2'd3, 32'h31, 32'h32, 2'd0);
    step(1'b0, 2'd1, 32'h33, 32'h99, 2'd0);
    chk("pre_flush_wcap", W'(o_wcapacity), 32'd1);
    chk("pre_flush_rdata0", o_rdata0, 32'h31);
    step(1'b1, 2'd2, 32'h44, 32'h55, 2'd2);
    chk("flush_rcount", W'(o_rcount), 32'd0);
    chk("flush_wcap", W'(o_wcapacity), 32'd2);
    step(1'b0, 2'd1, 32'hAA, 32'h0, 2'd0);
    chk("post_flush_rcount", W'(o_rcount), 32'd1);
    chk("post_flush_rdata0", o_rdata0, 32'hAA);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd1);

    // asynchronous reset mid-cycle at occ=3
    step(1'b0, 2'd2, 32'h61, 32'h62, 2'd0);
    step(1'b0, 2'd1, 32'h63, 32'h0, 2'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_rcount", W'(o_rcount), 32'd0);
    chk("arst_wcap", W'(o_wcapacity), 32'd2);
    chk("arst_rdata0", o_rdata0, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    step(1'b0, 2'd2, 32'h71, 32'h72, 2'd0);
    chk("arst_after_rdata0", o_rdata0, 32'h71);
    chk("arst_after_rdata1", o_rdata1, 32'h72);
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("arst_after_drain", W'(o_rcount), 32'd0);

    repeat (2) @(posedge i_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
